drp_responder: RTL

- DRP target (slave) that answers DRP transactions with DEN/DWE/DADDR/DI in and DO/DRDY out.
- It acts as the responder to the XADC-style DRP initiator used in the design. It supplies a bench/soft-peripheral register bank, so host-side DRP initiator logic can run without a hard XADC primitive.
- It exposes NREGS read/write control registers, one read-only live status word and one W1C error register. Response latency is programmable.

---
 rtl/drp_pkg.sv | 22 ++
 rtl/drp_responder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/drp_pkg.sv
// rtl/drp_pkg.sv - shared DRP widths, FSM state type, error bit positions
`timescale 1ns/1ps
package drp_pkg;

    localparam int DRP_AW = 7;
    localparam int DRP_DW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } drp_state_t;

    localparam int ERR_DECODE  = 0;
    localparam int ERR_OVERLAP = 1;

    // True when the address selects one of the R/W control registers
    function automatic logic addr_is_reg(input logic [DRP_AW-1:0] addr, input int nregs);
        return (int'(addr) < nregs);
    endfunction

endpackage

// File: rtl/drp_responder.sv
// rtl/drp_responder.sv - DRP target with R/W register bank, live status word and W1C error flags
`timescale 1ns/1ps
module drp_responder
    import drp_pkg::*;
#(
    parameter int          NREGS     = 16,
    parameter int          LATENCY   = 3,
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    den,
    input  logic                    dwe,
    input  logic [DRP_AW-1:0]       daddr,
    input  logic [DRP_DW-1:0]       di,
    output logic [DRP_DW-1:0]       drp_do,
    output logic                    drdy,
    input  logic [DRP_DW-1:0]       status_in,
    output logic [DRP_DW*NREGS-1:0] regs_out,
    output logic                    wr_strobe,
    output logic [DRP_AW-1:0]       wr_addr
);

    localparam logic [DRP_AW-1:0] STATUS_ADDR = DRP_AW'(NREGS);
    localparam logic [DRP_AW-1:0] ERR_ADDR    = DRP_AW'(NREGS + 1);
    localparam logic [3:0]        CNT_INIT    = 4'(LATENCY - 1);

    drp_state_t state, state_n;
    logic [3:0]              cnt;
    logic [DRP_AW-1:0]       addr_q;
    logic [DRP_DW-1:0]       di_q;
    logic                    we_q;
    logic                    accept;
    logic                    commit;
    logic [DRP_AW-1:0]       cur_addr;
    logic [DRP_DW-1:0]       cur_di;
    logic                    cur_we;
    logic [DRP_DW*NREGS-1:0] regs_q;
    logic [DRP_DW-1:0]       rd_data;
    logic                    decode_err;
    logic                    overlap_err;
    logic                    w1c;

    // Next-state: accept requests in IDLE and RESP, count down in WAIT; commit on any edge entering RESP
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE, RESP: begin
                if (den) begin
                    accept  = 1'b1;
                    state_n = (LATENCY == 1) ? RESP : WAIT;
                end else begin
                    state_n = IDLE;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_n = RESP;
                end
            end
            default: state_n = IDLE;
        endcase
        commit = (state_n == RESP);
    end

    // With LATENCY==1 the commit edge is also the accept edge, so the live inputs are used directly
    assign cur_addr = accept ? daddr : addr_q;
    assign cur_di   = accept ? di    : di_q;
    assign cur_we   = accept ? dwe   : we_q;
    assign w1c      = commit && cur_we && (cur_addr == ERR_ADDR);
    assign regs_out = regs_q;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Request capture and latency counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            di_q   <= '0;
            we_q   <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            addr_q <= daddr;
            di_q   <= di;
            we_q   <= dwe;
            cnt    <= CNT_INIT;
        end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Register bank write on commit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regs_q <= {NREGS{RESET_VAL}};
        end else if (commit && cur_we) begin
            for (int k = 0; k < NREGS; k++) begin
                if (cur_addr == DRP_AW'(k)) begin
                    regs_q[DRP_DW*k +: DRP_DW] <= cur_di;
                end
            end
        end
    end

    // Read decode: registers, live status, error flags, zero elsewhere
    always_comb begin
        rd_data = '0;
        if (addr_is_reg(cur_addr, NREGS)) begin
            for (int k = 0; k < NREGS; k++) begin
                if (cur_addr == DRP_AW'(k)) begin
                    rd_data = regs_q[DRP_DW*k +: DRP_DW];
                end
            end
        end else if (cur_addr == STATUS_ADDR) begin
            rd_data = status_in;
        end else if (cur_addr == ERR_ADDR) begin
            rd_data[ERR_DECODE]  = decode_err;
            rd_data[ERR_OVERLAP] = overlap_err;
        end
    end

    // Sticky error flags; a set in the same cycle as a W1C clear wins
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            decode_err  <= 1'b0;
            overlap_err <= 1'b0;
        end else begin
            if (commit && (cur_addr > ERR_ADDR)) begin
                decode_err <= 1'b1;
            end else if (w1c && cur_di[ERR_DECODE]) begin
                decode_err <= 1'b0;
            end
            if (den && (state == WAIT)) begin
                overlap_err <= 1'b1;
            end else if (w1c && cur_di[ERR_OVERLAP]) begin
                overlap_err <= 1'b0;
            end
        end
    end

    // Response outputs, all launched on the commit edge; drp_do holds between reads
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drp_do    <= '0;
            drdy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
        end else begin
            drdy      <= commit;
            wr_strobe <= commit && cur_we && addr_is_reg(cur_addr, NREGS);
            if (commit && cur_we && addr_is_reg(cur_addr, NREGS)) begin
                wr_addr <= cur_addr;
            end
            if (commit && !cur_we) begin
                drp_do <= rd_data;
            end
        end
    end

endmodule
